// File: rtl/seven_seg_display_arbiter.sv
// Round-robin arbiter sharing a 4-digit multiplexed 7-segment display between two requesters.
// Optional leading-zero blanking is enabled with LEADING_ZERO_BLANK_EN.
module seven_seg_display_arbiter #(
    parameter int REFRESH_BITS = 20,
    parameter int MIN_HOLD     = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        src,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [0:6]  seg
);

    // state     | meaning
    // S_IDLE    | waiting for a request, grants issued here only
    // S_CONVERT | 16 shift-add-3 iterations on the captured value
    // S_COMMIT  | load digit registers, src and ovf
    // S_HOLD    | keep committed value on display, no grants
    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT, S_HOLD} state_e;

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]       HOLD_INIT = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0]       HOLD_ONE  = HOLD_W'(1);
    localparam logic [REFRESH_BITS-1:0] REF_ONE   = REFRESH_BITS'(1);

    state_e state_q, state_d;

    logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                    last_gnt_q, last_gnt_d;
    logic [15:0]             sh_q, sh_d;
    logic [15:0]             bcd_q, bcd_d;
    logic [3:0]              iter_q, iter_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    ovf_pend_q, ovf_pend_d;
    logic                    src_pend_q, src_pend_d;
    logic [15:0]             disp_q, disp_d;
    logic                    src_q, src_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

    logic        capture;
    logic        sel_src;
    logic [15:0] cap_val;
    logic        clamp;
    logic [15:0] bcd_adj;
    logic [1:0]  digit_sel;
    logic [3:0]  cur_digit;

    function automatic logic [0:6] seg_decode(input logic [3:0] d);
        logic [0:6] p;
        case (d)
            4'd0:    p = 7'b0000001;
            4'd1:    p = 7'b1001111;
            4'd2:    p = 7'b0010010;
            4'd3:    p = 7'b0000110;
            4'd4:    p = 7'b1001100;
            4'd5:    p = 7'b0100100;
            4'd6:    p = 7'b0100000;
            4'd7:    p = 7'b0001111;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0000100;
            default: p = 7'b0000001;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req0 || req1) state_d = S_CONVERT;
            S_CONVERT: if (iter_q == 4'd0) state_d = S_COMMIT;
            S_COMMIT:  state_d = (MIN_HOLD == 0) ? S_IDLE : S_HOLD;
            S_HOLD:    if (hold_q == '0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // On a tie the requester not granted last wins.
    always_comb begin
        capture = (state_q == S_IDLE) && (req0 || req1);
        sel_src = (req0 && req1) ? ~last_gnt_q : req1;
        cap_val = sel_src ? data1 : data0;
        clamp   = (cap_val > 16'd9999);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        last_gnt_d = last_gnt_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        hold_d     = hold_q;
        ovf_pend_d = ovf_pend_q;
        src_pend_d = src_pend_q;
        disp_d     = disp_q;
        src_d      = src_q;
        ovf_d      = ovf_q;
        refresh_d  = refresh_q + REF_ONE;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    sh_d       = clamp ? 16'd9999 : cap_val;
                    bcd_d      = 16'd0;
                    iter_d     = 4'd15;
                    ovf_pend_d = clamp;
                    src_pend_d = sel_src;
                    last_gnt_d = sel_src;
                    gnt0_d     = ~sel_src;
                    gnt1_d     = sel_src;
                end
            end
            S_CONVERT: begin
                {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                iter_d        = iter_q - 4'd1;
            end
            S_COMMIT: begin
                disp_d = bcd_q;
                src_d  = src_pend_q;
                ovf_d  = ovf_pend_q;
                hold_d = HOLD_INIT;
            end
            S_HOLD: begin
                if (hold_q != '0) hold_d = hold_q - HOLD_ONE;
            end
            default: ;
        endcase
    end

    // Reset leaves last_gnt_q at 1 so that a tie after reset goes to req0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            last_gnt_q <= 1'b1;
            sh_q       <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            hold_q     <= '0;
            ovf_pend_q <= 1'b0;
            src_pend_q <= 1'b0;
            disp_q     <= '0;
            src_q      <= 1'b0;
            ovf_q      <= 1'b0;
            refresh_q  <= '0;
        end else begin
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            last_gnt_q <= last_gnt_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            hold_q     <= hold_d;
            ovf_pend_q <= ovf_pend_d;
            src_pend_q <= src_pend_d;
            disp_q     <= disp_d;
            src_q      <= src_d;
            ovf_q      <= ovf_d;
            refresh_q  <= refresh_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign src  = src_q;
    assign ovf  = ovf_q;

    always_comb begin
        digit_sel = refresh_q[REFRESH_BITS-1 -: 2];
        an        = 4'b1111;
        cur_digit = 4'd0;
        case (digit_sel)
            2'd0: begin an = 4'b0111; cur_digit = disp_q[15:12]; end
            2'd1: begin an = 4'b1011; cur_digit = disp_q[11:8];  end
            2'd2: begin an = 4'b1101; cur_digit = disp_q[7:4];   end
            default: begin an = 4'b1110; cur_digit = disp_q[3:0]; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_sel == 2'd0 && disp_q[15:12] == 4'd0) ||
            (digit_sel == 2'd1 && disp_q[15:8]  == 8'd0) ||
            (digit_sel == 2'd2 && disp_q[15:4]  == 12'd0)) begin
            an = 4'b1111;
        end
`else
`endif
        seg = seg_decode(cur_digit);
    end

endmodule
